vga_page_ctrl: RTL



---
 rtl/vga_page_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/vga_page_ctrl.sv
// Page scheduler for the VGA ball game: sequences the start/play/serve/over pages,
// tracks lives, and registers the selected colour source onto the VGA pins.
module vga_page_ctrl #(
    parameter int BLINK_FRAMES     = 30,
    parameter int SERVE_FRAMES     = 60,
    parameter int OVER_HOLD_FRAMES = 180,
    parameter int LIVES            = 3
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic       iFRAME_END,
    input  logic       iDISP_EN,
    input  logic       iKEY_START,
    input  logic       iBALL_MISS,
    input  logic [2:0] iSTART_RGB,
    input  logic [2:0] iGAME_RGB,
    input  logic [2:0] iOVER_RGB,
    output logic       oVGA_R,
    output logic       oVGA_G,
    output logic       oVGA_B,
    output logic       oGAME_RUN,
    output logic       oGAME_RESET,
    output logic [1:0] oLIVES,
    output logic [1:0] oPAGE
);

    localparam int MAX_AB     = (BLINK_FRAMES > SERVE_FRAMES) ? BLINK_FRAMES : SERVE_FRAMES;
    localparam int MAX_FRAMES = (MAX_AB > OVER_HOLD_FRAMES) ? MAX_AB : OVER_HOLD_FRAMES;
    localparam int CNT_W      = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;

    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);
    localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
    localparam logic [CNT_W-1:0] OVER_LAST  = CNT_W'(OVER_HOLD_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [1:0]       LIVES_INIT = 2'(LIVES);
    localparam logic [2:0]       BLUE_RGB   = 3'b001;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_PLAY  = 2'd1,
        ST_SERVE = 2'd2,
        ST_OVER  = 2'd3
    } page_t;

    page_t            state;
    page_t            state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             blue_phase;
    logic             blue_nxt;
    logic [1:0]       lives;
    logic [1:0]       lives_nxt;
    logic             pulse_nxt;
    logic             key_q;
    logic             key_edge;
    logic             start_req;
    logic             start_pend;
    logic             miss_req;
    logic             miss_pend;
    logic             game_run;
    logic             game_reset;
    logic [2:0]       src_rgb;
    logic [2:0]       pix_nxt;
    logic [2:0]       pix_p1;

    // Requests seen in the frame-end cycle itself are treated as already pending.
    always_comb begin
        key_edge   = iKEY_START & ~key_q;
        start_pend = start_req | key_edge;
        miss_pend  = miss_req | (iBALL_MISS & (state == ST_PLAY));

        state_nxt  = state;
        cnt_nxt    = cnt;
        blue_nxt   = blue_phase;
        lives_nxt  = lives;
        pulse_nxt  = 1'b0;

        if (iFRAME_END) begin
            case (state)
                ST_START: begin
                    if (start_pend) begin
                        lives_nxt = LIVES_INIT;
                        pulse_nxt = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = ST_PLAY;
                    end else if (cnt == BLINK_LAST) begin
                        cnt_nxt  = '0;
                        blue_nxt = ~blue_phase;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                ST_PLAY: begin
                    if (miss_pend) begin
                        cnt_nxt = '0;
                        if (lives > 2'd1) begin
                            lives_nxt = lives - 2'd1;
                            state_nxt = ST_SERVE;
                        end else begin
                            lives_nxt = 2'd0;
                            state_nxt = ST_OVER;
                        end
                    end
                end
                ST_SERVE: begin
                    if (cnt == SERVE_LAST) begin
                        cnt_nxt   = '0;
                        pulse_nxt = 1'b1;
                        state_nxt = ST_PLAY;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                ST_OVER: begin
                    if (cnt == OVER_LAST) begin
                        cnt_nxt   = '0;
                        blue_nxt  = 1'b0;
                        state_nxt = ST_START;
                    end else begin
                        cnt_nxt = cnt + CNT_ONE;
                    end
                end
                default: state_nxt = ST_START;
            endcase
        end
    end

    // Source mux follows the current page; a page change takes effect on later pixels.
    always_comb begin
        src_rgb = iGAME_RGB;
        case (state)
            ST_START: src_rgb = blue_phase ? BLUE_RGB : iSTART_RGB;
            ST_PLAY:  src_rgb = iGAME_RGB;
            ST_SERVE: src_rgb = iGAME_RGB;
            ST_OVER:  src_rgb = iOVER_RGB;
            default:  src_rgb = iGAME_RGB;
        endcase
        pix_nxt = iDISP_EN ? src_rgb : 3'b000;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state      <= ST_START;
            cnt        <= '0;
            blue_phase <= 1'b0;
            lives      <= 2'd0;
            key_q      <= 1'b0;
            start_req  <= 1'b0;
            miss_req   <= 1'b0;
            game_run   <= 1'b0;
            game_reset <= 1'b0;
            pix_p1     <= 3'b000;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            blue_phase <= blue_nxt;
            lives      <= lives_nxt;
            key_q      <= iKEY_START;
            start_req  <= iFRAME_END ? 1'b0 : start_pend;
            miss_req   <= iFRAME_END ? 1'b0 : miss_pend;
            game_run   <= (state_nxt == ST_PLAY);
            game_reset <= pulse_nxt;
            pix_p1     <= pix_nxt;
        end
    end

    assign {oVGA_R, oVGA_G, oVGA_B} = pix_p1;
    assign oGAME_RUN   = game_run;
    assign oGAME_RESET = game_reset;
    assign oLIVES      = lives;
    assign oPAGE       = state;

endmodule
